fir_coeff_loader: RTL and testbench

- Writer side of the filter's coefficient interface: accepts a serial stream of 16-bit coefficients and builds a complete half-bank in a shadow register file.
- Atomically publishes the shadow bank to the active bank the symmetric FIR multipliers read.
- Sits between the control/config path and the reduced-complexity FIR, replacing hard-wired coefficients with run-time loadable ones without glitching the filter mid-update.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_coeff_bank.sv | 57 +++++
 rtl/fir_coeff_loader.sv | 179 +++++++++++++++++
 tb/tb_fir_coeff_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR coefficient loader slice.
//   FIR_FILTER_SIZE / FIR_COEFF_W : default filter length and coefficient width
//   FIR_HALF_TAPS                 : number of stored (unique) coefficients
//   FIR_PTR_W                     : write pointer width
//   fir_state_t                   : loader FSM encoding
package fir_pkg;

    localparam int FIR_FILTER_SIZE = 172;
    localparam int FIR_COEFF_W     = 16;
    localparam int FIR_HALF_TAPS   = FIR_FILTER_SIZE / 2;
    localparam int FIR_PTR_W       = $clog2(FIR_HALF_TAPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2,
        CHECK = 2'd3
    } fir_state_t;

endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: shadow coefficient register file (single write port) and
// active register file updated from the shadow as a whole on copy_en.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (both arrays cleared)
//   wr_en, wr_addr,
//   wr_data           shadow write port
//   copy_en           copy every shadow entry into the active array
//   bank              active array, flattened; entry k at [k*W +: W]
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter  int N  = FIR_HALF_TAPS,
    parameter  int W  = FIR_COEFF_W,
    localparam int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [W-1:0]    wr_data,
    input  logic            copy_en,
    output logic [N*W-1:0]  bank
);

    logic [W-1:0] shadow [N];
    logic [W-1:0] active [N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_en) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                active[i] <= '0;
            end
        end else if (copy_en) begin
            for (int unsigned i = 0; i < N; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    always_comb begin
        bank = '0;
        for (int unsigned i = 0; i < N; i++) begin
            bank[i*W +: W] = active[i];
        end
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: serial coefficient loader for the symmetric FIR. Words are
// streamed into a shadow half-bank and published atomically to the active bank
// on commit, so the multipliers never see a partially updated bank.
// Optional feature: define COEFF_CHECKSUM_EN to require a trailing
// modulo-2^COEFF_W checksum word before the bank is marked full.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   load_start     pulse: open (or restart) a load
//   coeff_in       coefficient word
//   coeff_valid    coeff_in valid
//   coeff_ready    loader accepts a word this cycle
//   commit         pulse: publish shadow to active (only while bank_full)
//   coeff_bank     active bank; slice k = multiplier tap k
//   coeff_update   pulse in the first cycle the new coeff_bank is visible
//   bank_full      shadow complete, awaiting commit
//   load_err       pulse: load restarted (or checksum mismatch)
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter  int FILTER_SIZE = FIR_FILTER_SIZE,
    parameter  int COEFF_W     = FIR_COEFF_W,
    localparam int HALF_TAPS   = FILTER_SIZE / 2,
    localparam int PTR_W       = $clog2(HALF_TAPS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_start,
    input  logic [COEFF_W-1:0]        coeff_in,
    input  logic                      coeff_valid,
    output logic                      coeff_ready,
    input  logic                      commit,
    output logic [HALF_TAPS*COEFF_W-1:0] coeff_bank,
    output logic                      coeff_update,
    output logic                      bank_full,
    output logic                      load_err
);

    fir_state_t         state, state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic               accept;
    logic               last_word;
    logic               wr_en;
    logic               copy_en;
    logic               ptr_clr;
    logic               err_set;
    logic               upd_set;

`ifdef COEFF_CHECKSUM_EN
    logic [COEFF_W-1:0] sum;

    // Running sum wraps naturally at COEFF_W bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (load_start) begin
            sum <= '0;
        end else if (wr_en) begin
            sum <= sum + coeff_in;
        end
    end

    assign coeff_ready = (state == LOAD) || (state == CHECK);
`else
    assign coeff_ready = (state == LOAD);
`endif

    assign bank_full = (state == FULL);
    assign accept    = coeff_valid & coeff_ready;
    assign last_word = (ptr == PTR_W'(HALF_TAPS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A restart in the same cycle as a valid word drops that word: the new
    // load begins cleanly at pointer 0.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        copy_en   = 1'b0;
        ptr_clr   = 1'b0;
        err_set   = 1'b0;
        upd_set   = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                    ptr_clr   = 1'b1;
                end
            end
            LOAD: begin
                if (load_start) begin
                    ptr_clr = 1'b1;
                    err_set = 1'b1;
                end else if (accept) begin
                    wr_en = 1'b1;
                    if (last_word) begin
                        ptr_clr   = 1'b1;
`ifdef COEFF_CHECKSUM_EN
                        state_nxt = CHECK;
`else
                        state_nxt = FULL;
`endif
                    end
                end
            end
`ifdef COEFF_CHECKSUM_EN
            CHECK: begin
                if (load_start) begin
                    state_nxt = LOAD;
                    ptr_clr   = 1'b1;
                    err_set   = 1'b1;
                end else if (accept) begin
                    if (coeff_in == sum) begin
                        state_nxt = FULL;
                    end else begin
                        state_nxt = IDLE;
                        err_set   = 1'b1;
                    end
                end
            end
`endif
            FULL: begin
                // commit has priority over a simultaneous load_start
                if (commit) begin
                    state_nxt = IDLE;
                    copy_en   = 1'b1;
                    upd_set   = 1'b1;
                end else if (load_start) begin
                    state_nxt = LOAD;
                    ptr_clr   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (ptr_clr) begin
            ptr <= '0;
        end else if (wr_en) begin
            ptr <= ptr + 1'b1;
        end
    end

    // The active bank is written at the commit edge, so registering the
    // update strobe aligns it with the first cycle the new bank is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coeff_update <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            coeff_update <= upd_set;
            load_err     <= err_set;
        end
    end

    fir_coeff_bank #(
        .N (HALF_TAPS),
        .W (COEFF_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (ptr),
        .wr_data (coeff_in),
        .copy_en (copy_en),
        .bank    (coeff_bank)
    );

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: directed self-checking bench for fir_coeff_loader.
// Honours COEFF_CHECKSUM_EN the same way as the design.
module tb_fir_coeff_loader;
    import fir_pkg::*;

    localparam int HT = FIR_HALF_TAPS;
    localparam int CW = FIR_COEFF_W;
`ifdef COEFF_CHECKSUM_EN
    localparam logic CK = 1'b1;
`else
    localparam logic CK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic [CW-1:0]     coeff_in;
    logic              coeff_valid;
    logic              coeff_ready;
    logic              commit;
    logic [HT*CW-1:0]  coeff_bank;
    logic              coeff_update;
    logic              bank_full;
    logic              load_err;

    int n_cmp = 0;
    int n_bad = 0;
    int got;

    always #5 clk = ~clk;

    fir_coeff_loader #(
        .FILTER_SIZE (FIR_FILTER_SIZE),
        .COEFF_W     (FIR_COEFF_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .coeff_in     (coeff_in),
        .coeff_valid  (coeff_valid),
        .coeff_ready  (coeff_ready),
        .commit       (commit),
        .coeff_bank   (coeff_bank),
        .coeff_update (coeff_update),
        .bank_full    (bank_full),
        .load_err     (load_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic do_commit;
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    // Stream n words (ramp idx+1, or a constant); toggle mode drives valid
    // every other cycle with a 5-cycle gap. Returns the number accepted.
    task automatic push(input int n, input bit toggle, input bit use_const,
                        input logic [CW-1:0] cval, output int accepted);
        int idx;
        int cyc;
        logic v;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 1000) begin
            v = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (toggle && cyc >= 20 && cyc < 25) v = 1'b0;
            coeff_valid = v;
            coeff_in    = use_const ? cval : CW'(idx + 1);
            if (v && coeff_ready) idx++;
            tick();
            cyc++;
        end
        coeff_valid = 1'b0;
        accepted = idx;
    endtask

    task automatic finish_load(input logic [CW-1:0] csum);
        if (CK) begin
            coeff_in    = csum;
            coeff_valid = 1'b1;
            tick();
            coeff_valid = 1'b0;
        end
    endtask

    task automatic check_ramp(input string tag);
        for (int k = 0; k < HT; k++)
            check_val($sformatf("%s[%0d]", tag, k), 32'(coeff_bank[k*CW +: CW]), 32'(k + 1));
    endtask

    task automatic check_const(input string tag, input logic [CW-1:0] v);
        for (int k = 0; k < HT; k++)
            check_val($sformatf("%s[%0d]", tag, k), 32'(coeff_bank[k*CW +: CW]), 32'(v));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_start = 1'b0; coeff_in = '0; coeff_valid = 1'b0; commit = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Reset state; commit in IDLE is ignored
        check_val("rst_ready", 32'(coeff_ready), 32'd0);
        check_val("rst_full", 32'(bank_full), 32'd0);
        check_val("rst_upd", 32'(coeff_update), 32'd0);
        check_val("rst_err", 32'(load_err), 32'd0);
        check_val("rst_bank", 32'(|coeff_bank), 32'd0);
        do_commit();
        check_val("idle_commit_upd", 32'(coeff_update), 32'd0);

        // Continuous ramp 1..86
        pulse_start();
        check_val("t2_ready_on", 32'(coeff_ready), 32'd1);
        push(HT, 1'b0, 1'b0, '0, got);
        check_val("t2_accepted", 32'(got), 32'(HT));
        check_val("t2_ready_after", 32'(coeff_ready), 32'(CK));
        finish_load(16'd3741);
        check_val("t2_ready_off", 32'(coeff_ready), 32'd0);
        check_val("t2_full", 32'(bank_full), 32'd1);
        coeff_in = 16'hDEAD; coeff_valid = 1'b1;
        repeat (2) tick();
        coeff_valid = 1'b0;
        check_val("t2_full_hold", 32'(bank_full), 32'd1);
        check_val("t2_bank_stable", 32'(coeff_bank[0 +: CW]), 32'd0);
        do_commit();
        check_val("t2_upd", 32'(coeff_update), 32'd1);
        check_val("t2_slice0", 32'(coeff_bank[0 +: CW]), 32'd1);
        check_val("t2_slice85", 32'(coeff_bank[(HT-1)*CW +: CW]), 32'(HT));
        check_val("t2_full_clr", 32'(bank_full), 32'd0);
        tick();
        check_val("t2_upd_pulse", 32'(coeff_update), 32'd0);
        check_val("t2_idle_ready", 32'(coeff_ready), 32'd0);

        // Toggled valid with gap; commit and load_start together
        pulse_start();
        push(HT, 1'b1, 1'b0, '0, got);
        check_val("t3_accepted", 32'(got), 32'(HT));
        finish_load(16'd3741);
        check_val("t3_full", 32'(bank_full), 32'd1);
        commit = 1'b1; load_start = 1'b1;
        tick();
        commit = 1'b0; load_start = 1'b0;
        check_val("t3_upd", 32'(coeff_update), 32'd1);
        check_val("t3_ready_dropped", 32'(coeff_ready), 32'd0);
        check_val("t3_full_clr", 32'(bank_full), 32'd0);
        check_ramp("t3_bank");
        tick();
        check_val("t3_stay_idle", 32'(coeff_ready), 32'd0);

        // Restart after 40 words, then full 0x7FFF load
        pulse_start();
        push(40, 1'b0, 1'b1, 16'h1234, got);
        check_val("t4_partial", 32'(got), 32'd40);
        pulse_start();
        check_val("t4_err", 32'(load_err), 32'd1);
        check_val("t4_ready", 32'(coeff_ready), 32'd1);
        tick();
        check_val("t4_err_pulse", 32'(load_err), 32'd0);
        push(HT, 1'b0, 1'b1, 16'h7FFF, got);
        check_val("t4_accepted", 32'(got), 32'(HT));
        finish_load(16'hFFAA);
        check_val("t4_full", 32'(bank_full), 32'd1);
        check_val("t4_prior0", 32'(coeff_bank[0 +: CW]), 32'd1);
        check_val("t4_prior85", 32'(coeff_bank[(HT-1)*CW +: CW]), 32'(HT));
        do_commit();
        check_val("t4_upd", 32'(coeff_update), 32'd1);
        check_val("t4_err_quiet", 32'(load_err), 32'd0);
        check_const("t4_bank", 16'h7FFF);

        // Asynchronous reset mid-load, then a clean load
        pulse_start();
        push(50, 1'b0, 1'b0, '0, got);
        #2 reset = 1'b1;
        #1;
        check_val("t5_ready", 32'(coeff_ready), 32'd0);
        check_val("t5_full", 32'(bank_full), 32'd0);
        check_val("t5_bank", 32'(|coeff_bank), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        pulse_start();
        push(HT, 1'b0, 1'b0, '0, got);
        check_val("t5_accepted", 32'(got), 32'(HT));
        finish_load(16'd3741);
        check_val("t5_full_after", 32'(bank_full), 32'd1);
        do_commit();
        check_val("t5_upd", 32'(coeff_update), 32'd1);
        check_ramp("t5_bank");

`ifdef COEFF_CHECKSUM_EN
        // Checksum mismatch leaves the active bank untouched
        pulse_start();
        push(HT, 1'b0, 1'b1, 16'h0055, got);
        check_val("t6_in_check", 32'(coeff_ready), 32'd1);
        check_val("t6_not_full", 32'(bank_full), 32'd0);
        finish_load(16'd3740);
        check_val("t6_err", 32'(load_err), 32'd1);
        check_val("t6_full", 32'(bank_full), 32'd0);
        check_val("t6_idle", 32'(coeff_ready), 32'd0);
        tick();
        check_val("t6_err_pulse", 32'(load_err), 32'd0);
        do_commit();
        check_val("t6_no_upd", 32'(coeff_update), 32'd0);
        check_ramp("t6_bank");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
